// File: rtl/latch_edge_monitor.sv
// latch_edge_monitor
//   Takes the q output of a level-sensitive latch, which is asynchronous to
//   the system clock. It synchronizes q, glitch-filters it and produces:
//     - a clean registered level;
//     - one-cycle pulses on every accepted rising and falling transition;
//     - saturating transition counters for test and diagnostics.
//
// Ports:
//   clock      in   system clock, all state updates on the rising edge
//   reset_n    in   asynchronous active-low reset (release synchronous to clock)
//   q_in       in   latch q output, asynchronous to clock
//   clear      in   synchronous clear of both counters and sat
//   q_filt     out  filtered, synchronized level of q_in
//   rise       out  one-cycle pulse on an accepted 0->1 transition
//   fall       out  one-cycle pulse on an accepted 1->0 transition
//   rise_cnt   out  count of accepted rising transitions, saturating
//   fall_cnt   out  count of accepted falling transitions, saturating
//   sat        out  sticky: a counter was all-ones when an increment arrived
//   fsm_state  out  current filter state (S_LOW/S_RISE/S_HIGH/S_FALL), debug
//
// Interface timing: q_in carries no handshake. It is only ever sampled by
// the first synchronizer flop. clear is a plain level that is sampled on
// each rising edge. All outputs are registered.
// Latency from a clean q_in change to q_filt/pulse is SYNC+FILT edges.

module latch_edge_monitor #(
  parameter int SYNC  = 2,  // synchronizer depth, >= 2
  parameter int FILT  = 3,  // cycles a new level must persist, >= 1
  parameter int CNT_W = 8   // transition counter width, >= 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             q_in,
  input  logic             clear,
  output logic             q_filt,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             sat,
  output logic [1:0]       fsm_state
);

  localparam int STAB_W = $clog2(FILT + 1);
  localparam logic [STAB_W-1:0] FILT_V   = STAB_W'(FILT);
  localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Synchronizer: q_in is sampled here and nowhere else.
  // ---------------------------------------------------------------------
  logic [SYNC-1:0] sync_q;
  logic            q_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], q_in};
    end
  end

  assign q_s = sync_q[SYNC-1];

  // ---------------------------------------------------------------------
  // Filter FSM. stab counts consecutive samples at the candidate level.
  // A qualification is accepted when the next sample would bring the
  // count to FILT. The pulse and q_filt are registered on that same edge.
  // ---------------------------------------------------------------------
  state_t            state;
  logic [STAB_W-1:0] stab;
  logic [STAB_W-1:0] stab_inc;

  assign stab_inc  = stab + STAB_ONE;
  assign fsm_state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_LOW;
      stab   <= '0;
      q_filt <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        S_LOW: begin
          if (q_s) begin
            if (FILT == 1) begin
              state  <= S_HIGH;
              stab   <= '0;
              q_filt <= 1'b1;
              rise   <= 1'b1;
            end else begin
              state <= S_RISE;
              stab  <= STAB_ONE;
            end
          end
        end
        S_RISE: begin
          if (!q_s) begin
            // Glitch shorter than FILT: drop it silently.
            state <= S_LOW;
            stab  <= '0;
          end else if (stab_inc == FILT_V) begin
            state  <= S_HIGH;
            stab   <= '0;
            q_filt <= 1'b1;
            rise   <= 1'b1;
          end else begin
            stab <= stab_inc;
          end
        end
        S_HIGH: begin
          if (!q_s) begin
            if (FILT == 1) begin
              state  <= S_LOW;
              stab   <= '0;
              q_filt <= 1'b0;
              fall   <= 1'b1;
            end else begin
              state <= S_FALL;
              stab  <= STAB_ONE;
            end
          end
        end
        S_FALL: begin
          if (q_s) begin
            state <= S_HIGH;
            stab  <= '0;
          end else if (stab_inc == FILT_V) begin
            state  <= S_LOW;
            stab   <= '0;
            q_filt <= 1'b0;
            fall   <= 1'b1;
          end else begin
            stab <= stab_inc;
          end
        end
        default: begin
          state <= S_LOW;
          stab  <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Transition counters. They increment the cycle after a pulse.
  // clear takes priority, but a pulse that is due in the same cycle still
  // counts, so that event is not lost (the counter becomes 1 and sat is 0).
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rise_cnt <= '0;
      fall_cnt <= '0;
      sat      <= 1'b0;
    end else if (clear) begin
      rise_cnt <= {{(CNT_W-1){1'b0}}, rise};
      fall_cnt <= {{(CNT_W-1){1'b0}}, fall};
      sat      <= 1'b0;
    end else begin
      if (rise) begin
        if (&rise_cnt) sat <= 1'b1;
        else           rise_cnt <= rise_cnt + 1'b1;
      end
      if (fall) begin
        if (&fall_cnt) sat <= 1'b1;
        else           fall_cnt <= fall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_latch_edge_monitor.sv
// Testbench for latch_edge_monitor. It instantiates two copies: one with the
// defaults and one with CNT_W=2. Both share the same inputs. The reference
// model works from the observable rules: q_in is seen SYNC edges late, and a
// level flips once FILT consecutive seen samples disagree with it.

module tb_latch_edge_monitor;

  localparam int SYNC = 2;
  localparam int FILT = 3;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // stimulus sources: direct drive or a behavioural d-latch
  logic q_drv = 1'b0;
  logic use_latch = 1'b0;
  logic lat_en = 1'b0;
  logic lat_d = 1'b0;
  logic lat_q = 1'b0;
  logic q_in;
  logic clear = 1'b0;

  always_latch begin
    if (lat_en) lat_q <= lat_d;
  end
  assign q_in = use_latch ? lat_q : q_drv;

  // DUT outputs
  logic       q_filt, rise, fall, sat;
  logic [7:0] rise_cnt, fall_cnt;
  logic [1:0] fsm_state;
  logic       s_q_filt, s_rise, s_fall, s_sat;
  logic [1:0] s_rise_cnt, s_fall_cnt;
  logic [1:0] s_fsm_state;

  latch_edge_monitor dut (
    .clock(clock), .reset_n(reset_n), .q_in(q_in), .clear(clear),
    .q_filt(q_filt), .rise(rise), .fall(fall),
    .rise_cnt(rise_cnt), .fall_cnt(fall_cnt), .sat(sat),
    .fsm_state(fsm_state)
  );

  latch_edge_monitor #(.CNT_W(2)) dut_s (
    .clock(clock), .reset_n(reset_n), .q_in(q_in), .clear(clear),
    .q_filt(s_q_filt), .rise(s_rise), .fall(s_fall),
    .rise_cnt(s_rise_cnt), .fall_cnt(s_fall_cnt), .sat(s_sat),
    .fsm_state(s_fsm_state)
  );

  // reference model
  logic samp_q[$];
  int   run;
  logic m_filt, m_rise, m_fall;
  int   cmax [2] = '{255, 3};
  int   rc   [2];
  int   fc   [2];
  logic st   [2];

  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    samp_q.delete();
    for (int i = 0; i < SYNC; i++) samp_q.push_front(1'b0);
    run = 0;
    m_filt = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rc[k] = 0; fc[k] = 0; st[k] = 1'b0;
    end
  endtask

  // One rising edge. Inputs are the values present just before the edge.
  task automatic model_edge(input logic qin, input logic cl);
    logic seen, pr, pf;
    if (!reset_n) begin
      model_reset();
      return;
    end
    pr = m_rise;
    pf = m_fall;
    seen = samp_q.pop_back();
    samp_q.push_front(qin);
    for (int k = 0; k < 2; k++) begin
      if (cl) begin
        rc[k] = pr ? 1 : 0;
        fc[k] = pf ? 1 : 0;
        st[k] = 1'b0;
      end else begin
        if (pr) begin
          if (rc[k] == cmax[k]) st[k] = 1'b1; else rc[k]++;
        end
        if (pf) begin
          if (fc[k] == cmax[k]) st[k] = 1'b1; else fc[k]++;
        end
      end
    end
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (seen != m_filt) begin
      run++;
      if (run == FILT) begin
        m_filt = seen;
        if (seen) m_rise = 1'b1; else m_fall = 1'b1;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("q_filt",     32'(q_filt),     32'(m_filt));
    chk("rise",       32'(rise),       32'(m_rise));
    chk("fall",       32'(fall),       32'(m_fall));
    chk("rise_cnt",   32'(rise_cnt),   32'(rc[0]));
    chk("fall_cnt",   32'(fall_cnt),   32'(fc[0]));
    chk("sat",        32'(sat),        32'(st[0]));
    chk("s_rise_cnt", 32'(s_rise_cnt), 32'(rc[1]));
    chk("s_fall_cnt", 32'(s_fall_cnt), 32'(fc[1]));
    chk("s_sat",      32'(s_sat),      32'(st[1]));
  endtask

  // Driver: set inputs away from the edge, clock once, then compare.
  task automatic step(input logic qv, input logic cl);
    logic qs;
    q_drv = qv;
    clear = cl;
    #1;
    qs = q_in;
    @(posedge clock);
    model_edge(qs, cl);
    #1;
    check_all();
  endtask

  task automatic hold(input logic qv, input int n);
    for (int i = 0; i < n; i++) step(qv, 1'b0);
  endtask

  initial begin
    int   len;
    logic lvl;
    model_reset();

    // 1: power-up with q_in high
    reset_n = 1'b0;
    hold(1'b1, 3);
    reset_n = 1'b1;
    hold(1'b1, 8);
    chk("tp1_rise_cnt", 32'(rise_cnt), 32'd1);

    // 2: clean high then low
    hold(1'b0, 10);
    hold(1'b1, 10);
    hold(1'b0, 10);
    chk("tp2_fall_cnt", 32'(fall_cnt), 32'd2);

    // 3: short pulse rejected, FILT-wide pulse accepted
    hold(1'b1, 2);
    hold(1'b0, 10);
    chk("tp3_reject", 32'(rise_cnt), 32'd2);
    hold(1'b1, 3);
    hold(1'b0, 10);
    chk("tp3_accept", 32'(rise_cnt), 32'd3);

    // 4: saturate the 2-bit copy, then clear
    for (int p = 0; p < 5; p++) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end
    chk("tp4_s_rise_sat", 32'(s_rise_cnt), 32'd3);
    chk("tp4_s_sat",      32'(s_sat),      32'd1);
    step(1'b0, 1'b1);
    chk("tp4_clr_s_sat",  32'(s_sat),      32'd0);

    // 5: clear on the same edge as a due increment
    reset_n = 1'b0;
    hold(1'b0, 2);
    reset_n = 1'b1;
    hold(1'b0, 6);
    for (int p = 0; p < 7; p++) begin
      hold(1'b1, 4);
      hold(1'b0, 6);
    end
    chk("tp5_pre", 32'(rise_cnt), 32'd7);
    begin
      int budget = 20;
      step(1'b1, 1'b0);
      while (!m_rise && budget > 0) begin
        step(1'b1, 1'b0);
        budget--;
      end
      chk("tp5_rise_seen", 32'(rise), 32'd1);
    end
    step(1'b1, 1'b1);
    chk("tp5_cnt", 32'(rise_cnt), 32'd1);
    chk("tp5_sat", 32'(sat),      32'd0);
    hold(1'b1, 3);
    hold(1'b0, 10);

    // 6: latch-driven q_in, async reset mid-qualification
    use_latch = 1'b1;
    lat_d = 1'b1;
    lat_en = 1'b1;
    hold(1'b0, 3);
    lat_en = 1'b0;
    lat_d = ~lat_d;
    hold(1'b0, 1);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("tp6_q_filt", 32'(q_filt), 32'd0);
    for (int i = 0; i < 2; i++) begin
      lat_d = ~lat_d;
      hold(1'b0, 1);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lat_d = ~lat_d;
      hold(1'b0, 1);
    end
    chk("tp6_rise_cnt", 32'(rise_cnt), 32'd1);
    use_latch = 1'b0;

    // random runs with occasional clear
    lvl = 1'b0;
    for (int r = 0; r < 80; r++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) step(lvl, ($urandom_range(0, 15) == 0));
    end
    hold(1'b0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/latch_edge_monitor.md
Name: latch_edge_monitor

Overview:
Downstream consumer of the d_latch output. Takes the latch's q, which is asynchronous to the system clock, and synchronizes and glitch-filters it. It produces a clean registered level, one-cycle rise/fall pulses, and saturating transition counters for test and diagnostics. It sits between any latch-based storage element and synchronous control logic.

Parameters:
SYNC, 2, synchronizer depth in flops (legal >= 2)
FILT, 3, consecutive sampled cycles a new level must persist before acceptance (legal >= 1)
CNT_W, 8, width of each transition counter (legal >= 2)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset; assertion clears all state immediately, deassertion is synchronous to clock
q_in  input  1  latch q output, asynchronous to clock
clear  input  1  synchronous clear of counters and sat flag
q_filt  output  1  filtered, synchronized level of q_in
rise  output  1  one-cycle pulse on accepted 0->1 transition
fall  output  1  one-cycle pulse on accepted 1->0 transition
rise_cnt  output  CNT_W  accepted rising transitions, saturating
fall_cnt  output  CNT_W  accepted falling transitions, saturating
sat  output  1  sticky: a counter was at all-ones when an increment arrived

Behaviour:
- Reset, while reset_n=0:
  - All synchronizer flops, q_filt, rise, fall, both counters and sat are 0.
  - FSM is in S_LOW; stability counter is 0.
  - Reset asserted mid-qualification abandons that qualification; no pulse is produced.
- Synchronizer: a SYNC-deep flop chain samples q_in; its last stage is q_s. No other logic touches q_in.
- FSM states S_LOW, S_RISE, S_HIGH, S_FALL; stab counter is ceil(log2(FILT+1)) bits.
  - S_LOW: q_s=1 -> if FILT=1, go to S_HIGH (accept); else go to S_RISE with stab=1.
  - S_RISE: q_s=0 -> S_LOW, stab=0 (glitch rejected, no pulse, no count). q_s=1 -> stab+1; when stab+1 == FILT, go to S_HIGH (accept).
  - S_HIGH and S_FALL: mirror images of S_LOW and S_RISE with q_s polarity inverted.
- Accept:
  - On the accepting edge, q_filt takes the new level and rise (or fall) is 1 for exactly that cycle.
  - All outputs are registered.
- Latency: a clean q_in change to the q_filt change, and to the pulse, is SYNC+FILT clock edges (5 with defaults).
- A level held fewer than FILT consecutive sampled cycles never propagates. Minimum accepted pulse width is FILT cycles.
- Counters:
  - The cycle after rise=1, rise_cnt increments; fall_cnt behaves the same on fall=1.
  - At all-ones the counter holds and sat sets. sat stays 1 until clear or reset.
- clear:
  - Zeroes rise_cnt, fall_cnt and sat on the next edge; the FSM and q_filt are unaffected.
  - If an increment is due in the same cycle as clear, the result is 1 for that counter and sat is 0.
- rise and fall are never 1 in the same cycle. Consecutive accepts are at least FILT cycles apart.
- Power-up level: if q_in is 1 at reset release, the block reports one rise after SYNC+FILT cycles, so rise_cnt=1.

Test Plan:
1. Reset_n=0 with q_in=1, then release -> q_filt=0 and all counts 0 during reset; after 5 edges q_filt=1, rise=1 for exactly one cycle, then rise_cnt=1.
2. Defaults, q_in 0->1 held 10 cycles then 1->0 -> rise 5 edges after the change; fall 5 edges after the second change; rise_cnt=1, fall_cnt=1, sat=0.
3. q_in high for exactly 2 cycles (< FILT=3), then low -> q_filt stays 0, no pulses, counts stay 0. Repeat with 3 cycles -> accepted: rise then fall, each count 1.
4. CNT_W=2, 5 clean high/low pulses of 8 cycles each -> rise_cnt saturates at 3 after the 3rd pulse, sat=1 on the 4th, counts hold at 3 through the 5th; clear -> counts 0, sat 0.
5. clear asserted in the cycle a rise increment is due, with rise_cnt=7 beforehand -> rise_cnt=1, sat=0.
6. Drive a d_latch with clock/d toggling every cycle, feeding q_in while in S_RISE; assert reset_n=0 asynchronously mid-qualification -> all outputs 0 with no clock edge; after release, behaviour matches scenario 1.
